lopd_norm_pipe: RTL

Parametrised, pipelined leading-one position detector with an integrated left-shift normaliser. It is intended for the FP add/sub datapath after mantissa subtraction. Per transaction it returns:
- the leading-zero count (position of the leading one, counted from the MSB);
- the zero flag;
- the mantissa shifted so its leading one sits at the MSB.

It uses a valid/ready elastic pipeline, so it stalls under downstream backpressure without losing data.

---
 rtl/lopd_pkg.sv | 30 +++
 rtl/lopd_grp_enc.sv | 27 ++
 rtl/lopd_norm_pipe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/lopd_pkg.sv
// Shared constants, helpers and the default payload layout for the
// leading-one position detector / normaliser.
package lopd_pkg;

    localparam int LOPD_DATA_W = 24;
    localparam int LOPD_GRP_W  = 8;
    localparam int LOPD_TAG_W  = 4;
    localparam int LOPD_NG     = LOPD_DATA_W / LOPD_GRP_W;
    localparam int LOPD_GC_W   = $clog2(LOPD_GRP_W);

    // Width of the leading-zero count for a given operand width.
    function automatic int lopd_cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

    // Position reported for an all-zero operand: all ones in cnt_w bits.
    function automatic int lopd_zero_pos(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

    // Group-stage payload for the default configuration; the top level
    // re-declares the same layout against its own parameters.
    typedef struct packed {
        logic [LOPD_DATA_W-1:0]            data;
        logic [LOPD_NG-1:0][LOPD_GC_W-1:0] grp_cnt;
        logic [LOPD_NG-1:0]                grp_zero;
        logic [LOPD_TAG_W-1:0]             tag;
    } lopd_payload_t;

endpackage

// File: rtl/lopd_grp_enc.sv
// Combinational leading-zero encoder for one GRP_W-bit group.
// An all-zero group reports an all-ones count and raises zero_o.
module lopd_grp_enc
    import lopd_pkg::*;
#(
    parameter int GRP_W = LOPD_GRP_W
) (
    input  logic [GRP_W-1:0]         grp_i,
    output logic [$clog2(GRP_W)-1:0] cnt_o,
    output logic                     zero_o
);

    localparam int GC_W = $clog2(GRP_W);

    // Scan LSB to MSB so the most-significant set bit wins.
    always_comb begin
        cnt_o  = '1;
        zero_o = 1'b1;
        for (int i = 0; i < GRP_W; i++) begin
            if (grp_i[i]) begin
                cnt_o  = GC_W'(GRP_W - 1 - i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lopd_norm_pipe.sv
// Pipelined leading-one position detector with left-shift normaliser.
// Elastic valid/ready pipeline of PIPE_STAGES register stages:
//   1: detect+combine+shift | out
//   2: group detect | combine+shift
//   3: group detect | combine | shift
module lopd_norm_pipe
    import lopd_pkg::*;
#(
    parameter int DATA_W      = LOPD_DATA_W,
    parameter int GRP_W       = LOPD_GRP_W,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = LOPD_TAG_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [DATA_W-1:0]         i_data,
    input  logic [TAG_W-1:0]          i_tag,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_norm_data,
    output logic [$clog2(DATA_W)-1:0] o_one_position,
    output logic                      o_zero_flag,
    output logic [TAG_W-1:0]          o_tag
);

    localparam int CNT_W = lopd_cnt_w(DATA_W);
    localparam int NG    = DATA_W / GRP_W;
    localparam int GC_W  = $clog2(GRP_W);
    localparam int N     = PIPE_STAGES;
    localparam logic [CNT_W-1:0] ZERO_POS = CNT_W'(lopd_zero_pos(CNT_W));

    typedef struct packed {
        logic [DATA_W-1:0]         data;
        logic [NG-1:0][GC_W-1:0]   grp_cnt;
        logic [NG-1:0]             grp_zero;
        logic [TAG_W-1:0]          tag;
    } grp_stage_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  pos;
        logic              zero;
        logic [TAG_W-1:0]  tag;
    } cmb_stage_t;

    typedef struct packed {
        logic [DATA_W-1:0] norm;
        logic [CNT_W-1:0]  pos;
        logic              zero;
        logic [TAG_W-1:0]  tag;
    } out_stage_t;

    if (DATA_W % GRP_W != 0) begin : g_chk_div
        $error("lopd_norm_pipe: DATA_W must be a multiple of GRP_W");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_chk_stages
        $error("lopd_norm_pipe: PIPE_STAGES must be 1..3");
    end
    if (GRP_W < 2 || (GRP_W & (GRP_W - 1)) != 0) begin : g_chk_grp
        $error("lopd_norm_pipe: GRP_W must be a power of 2, at least 2");
    end
    if (DATA_W < 8 || DATA_W > 64) begin : g_chk_width
        $error("lopd_norm_pipe: DATA_W must be 8..64");
    end

    // First non-zero group from the MSB side; lower index overrides.
    function automatic logic [CNT_W-1:0] comb_pos(input logic [NG-1:0][GC_W-1:0] cnt,
                                                  input logic [NG-1:0]           zf);
        logic [CNT_W-1:0] pos;
        pos = ZERO_POS;
        for (int g = NG - 1; g >= 0; g--) begin
            if (!zf[g]) pos = CNT_W'(g * GRP_W) + CNT_W'(cnt[g]);
        end
        return pos;
    endfunction

    function automatic logic [DATA_W-1:0] norm_shift(input logic [DATA_W-1:0] d,
                                                     input logic [CNT_W-1:0]  pos,
                                                     input logic              zero);
        return zero ? '0 : (d << pos);
    endfunction

    logic [NG-1:0][GC_W-1:0] grp_cnt_c;
    logic [NG-1:0]           grp_zero_c;

    for (genvar g = 0; g < NG; g++) begin : g_enc
        lopd_grp_enc #(.GRP_W(GRP_W)) u_enc (
            .grp_i  (i_data[DATA_W-1-g*GRP_W -: GRP_W]),
            .cnt_o  (grp_cnt_c[g]),
            .zero_o (grp_zero_c[g])
        );
    end

    logic [N-1:0] vld_q, vld_d, vld_in, ld, en;
    out_stage_t   fin_d, out_q;

    // Stage k loads when it or any later stage has a hole, or the sink takes the output.
    always_comb begin
        logic hole;
        hole = i_ready;
        ld   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            hole  = hole || !vld_q[k];
            ld[k] = hole;
        end
    end

    // Valid presented to each stage by its upstream neighbour.
    always_comb begin
        vld_in    = '0;
        vld_in[0] = i_valid;
        for (int k = 1; k < N; k++) vld_in[k] = vld_q[k-1];
    end

    // Next valid state and data capture enables.
    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < N; k++) begin
            if (ld[k]) vld_d[k] = vld_in[k];
        end
        en = ld & vld_in;
    end

    // Stage valid bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) vld_q <= '0;
        else          vld_q <= vld_d;
    end

    if (N == 1) begin : g_ps1
        logic [CNT_W-1:0] pos_c;
        logic             zero_c;
        assign pos_c  = comb_pos(grp_cnt_c, grp_zero_c);
        assign zero_c = &grp_zero_c;

        // Full detect, combine and shift straight from the input.
        always_comb begin
            fin_d.norm = norm_shift(i_data, pos_c, zero_c);
            fin_d.pos  = pos_c;
            fin_d.zero = zero_c;
            fin_d.tag  = i_tag;
        end
    end else if (N == 2) begin : g_ps2
        grp_stage_t       p0_q, p0_d;
        logic [CNT_W-1:0] pos_c;
        logic             zero_c;

        // Group-detect stage payload.
        always_comb begin
            p0_d.data     = i_data;
            p0_d.grp_cnt  = grp_cnt_c;
            p0_d.grp_zero = grp_zero_c;
            p0_d.tag      = i_tag;
        end

        // ---- stage 0 / stage 1 boundary ----
        always_ff @(posedge i_clk) begin
            if (en[0]) p0_q <= p0_d;
        end

        assign pos_c  = comb_pos(p0_q.grp_cnt, p0_q.grp_zero);
        assign zero_c = &p0_q.grp_zero;

        // Combine and shift from the registered group results.
        always_comb begin
            fin_d.norm = norm_shift(p0_q.data, pos_c, zero_c);
            fin_d.pos  = pos_c;
            fin_d.zero = zero_c;
            fin_d.tag  = p0_q.tag;
        end
    end else begin : g_ps3
        grp_stage_t p0_q, p0_d;
        cmb_stage_t p1_q, p1_d;

        // Group-detect stage payload.
        always_comb begin
            p0_d.data     = i_data;
            p0_d.grp_cnt  = grp_cnt_c;
            p0_d.grp_zero = grp_zero_c;
            p0_d.tag      = i_tag;
        end

        // ---- stage 0 / stage 1 boundary ----
        always_ff @(posedge i_clk) begin
            if (en[0]) p0_q <= p0_d;
        end

        // Combine group results into the final position.
        always_comb begin
            p1_d.data = p0_q.data;
            p1_d.pos  = comb_pos(p0_q.grp_cnt, p0_q.grp_zero);
            p1_d.zero = &p0_q.grp_zero;
            p1_d.tag  = p0_q.tag;
        end

        // ---- stage 1 / stage 2 boundary ----
        always_ff @(posedge i_clk) begin
            if (en[1]) p1_q <= p1_d;
        end

        // Barrel shift from the registered position.
        always_comb begin
            fin_d.norm = norm_shift(p1_q.data, p1_q.pos, p1_q.zero);
            fin_d.pos  = p1_q.pos;
            fin_d.zero = p1_q.zero;
            fin_d.tag  = p1_q.tag;
        end
    end

    // ---- output register: cleared on reset so the outputs read zero ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      out_q <= '0;
        else if (en[N-1])  out_q <= fin_d;
    end

    assign o_ready        = ld[0];
    assign o_valid        = vld_q[N-1];
    assign o_norm_data    = out_q.norm;
    assign o_one_position = out_q.pos;
    assign o_zero_flag    = out_q.zero;
    assign o_tag          = out_q.tag;

endmodule
